// File: rtl/cpu_pkg.sv
// Shared CPU constants and fetch/decode bundle types.
// Line-index and tag slices must stay in step with the branch target table.
package cpu_pkg;

    localparam int PC_W = 32;

    typedef logic [PC_W-1:0] pc_t;

    localparam pc_t PC_STEP      = 32'd4;
    localparam pc_t RESET_PC_DEF = 32'h0000_0000;

    localparam int IDX_HI = 5;
    localparam int IDX_LO = 2;
    localparam int TAG_HI = 31;
    localparam int TAG_LO = 6;

    typedef struct packed {
        logic valid;
        pc_t  pc4;
        logic pred_taken;
        logic pred_hit;
        pc_t  pred_dest;
    } if_id_t;

endpackage

// File: rtl/fetch_pc_ctrl_bt_update.sv
// Branch resolution compare and registered branch-table write strobes.
// Strobes are one-cycle pulses the cycle after a beq resolves.
module bt_update_gen
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic resolve_valid,
    input  logic resolve_taken,
    input  pc_t  resolve_target,
    input  logic id_valid,
    input  pc_t  id_pc4,
    input  logic id_pred_taken,
    input  logic id_pred_hit,
    input  pc_t  id_pred_dest,
    output logic res,
    output logic mispred,
    output pc_t  actual_next,
    output logic bt_wrt,
    output logic bt_wrp,
    output logic bt_pin,
    output pc_t  bt_destin,
    output pc_t  bt_pc4d
);

    pc_t  guessed_next;
    logic wrt_d, wrp_d, pin_d;
    logic wrt_q, wrp_q, pin_q;
    pc_t  destin_d, destin_q;
    pc_t  pc4d_d, pc4d_q;

    always_comb begin
        res          = resolve_valid & id_valid & ~stall;
        actual_next  = resolve_taken ? resolve_target : id_pc4;
        guessed_next = id_pred_taken ? id_pred_dest : id_pc4;
        mispred      = res & (actual_next != guessed_next);
    end

    // Not-taken misses write nothing so they never pollute the table.
    always_comb begin
        wrt_d    = 1'b0;
        wrp_d    = 1'b0;
        pin_d    = 1'b0;
        destin_d = destin_q;
        pc4d_d   = pc4d_q;
        if (res) begin
            destin_d = resolve_target;
            pc4d_d   = id_pc4;
            if (resolve_taken &&
                (!id_pred_hit || resolve_target != id_pred_dest)) begin
                wrt_d = 1'b1;
                wrp_d = 1'b1;
                pin_d = 1'b1;
            end else if (id_pred_hit) begin
                wrp_d = 1'b1;
                pin_d = resolve_taken;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrt_q    <= 1'b0;
            wrp_q    <= 1'b0;
            pin_q    <= 1'b0;
            destin_q <= '0;
            pc4d_q   <= '0;
        end else begin
            wrt_q    <= wrt_d;
            wrp_q    <= wrp_d;
            pin_q    <= pin_d;
            destin_q <= destin_d;
            pc4d_q   <= pc4d_d;
        end
    end

    assign bt_wrt    = wrt_q;
    assign bt_wrp    = wrp_q;
    assign bt_pin    = pin_q;
    assign bt_destin = destin_q;
    assign bt_pc4d   = pc4d_q;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: next-PC select, IF/ID register, redirect
// on beq mispredict or jump, and branch statistics counters.
module fetch_pc_ctrl
    import cpu_pkg::*;
#(
    parameter pc_t RESET_PC = RESET_PC_DEF,
    parameter int  CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    output pc_t              imem_addr,
    output pc_t              pc4,
    input  logic             bt_hit,
    input  logic             bt_pred,
    input  pc_t              bt_dest,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    input  pc_t              resolve_target,
    input  logic             jump_valid,
    input  pc_t              jump_target,
    output logic             id_valid,
    output pc_t              id_pc4,
    output logic             id_pred_taken,
    output logic             flush,
    output logic             bt_wrt,
    output logic             bt_wrp,
    output logic             bt_pin,
    output pc_t              bt_destin,
    output pc_t              bt_pc4d,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    pc_t              pc_q, pc_d;
    if_id_t           ifid_q, ifid_d;
    logic [CNT_W-1:0] branch_q, branch_d;
    logic [CNT_W-1:0] mispred_q, mispred_d;

    logic pred_taken;
    pc_t  pred_next;
    logic res, mispred, jmp;
    pc_t  actual_next;

    bt_update_gen u_upd (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .resolve_target(resolve_target),
        .id_valid      (ifid_q.valid),
        .id_pc4        (ifid_q.pc4),
        .id_pred_taken (ifid_q.pred_taken),
        .id_pred_hit   (ifid_q.pred_hit),
        .id_pred_dest  (ifid_q.pred_dest),
        .res           (res),
        .mispred       (mispred),
        .actual_next   (actual_next),
        .bt_wrt        (bt_wrt),
        .bt_wrp        (bt_wrp),
        .bt_pin        (bt_pin),
        .bt_destin     (bt_destin),
        .bt_pc4d       (bt_pc4d)
    );

    // A beq in decode takes priority over a simultaneous jump.
    always_comb begin
        pc4        = pc_q + PC_STEP;
        pred_taken = bt_hit & bt_pred;
        pred_next  = pred_taken ? bt_dest : pc4;
        jmp        = jump_valid & ifid_q.valid & ~stall & ~resolve_valid;
        flush      = mispred | jmp;
    end

    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (mispred) begin
            pc_d         = actual_next;
            ifid_d.valid = 1'b0;
        end else if (jmp) begin
            pc_d         = jump_target;
            ifid_d.valid = 1'b0;
        end else if (!stall) begin
            pc_d              = pred_next;
            ifid_d.valid      = 1'b1;
            ifid_d.pc4        = pc4;
            ifid_d.pred_taken = pred_taken;
            ifid_d.pred_hit   = bt_hit;
            ifid_d.pred_dest  = bt_dest;
        end
    end

    always_comb begin
        branch_d  = branch_q;
        mispred_d = mispred_q;
        if (res && branch_q != '1)
            branch_d = branch_q + CNT_W'(1);
        if (mispred && mispred_q != '1)
            mispred_d = mispred_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            ifid_q    <= '0;
            branch_q  <= '0;
            mispred_q <= '0;
        end else begin
            pc_q      <= pc_d;
            ifid_q    <= ifid_d;
            branch_q  <= branch_d;
            mispred_q <= mispred_d;
        end
    end

    assign imem_addr     = pc_q;
    assign id_valid      = ifid_q.valid;
    assign id_pc4        = ifid_q.pc4;
    assign id_pred_taken = ifid_q.pred_taken;
    assign branch_cnt    = branch_q;
    assign mispred_cnt   = mispred_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl; a second narrow-counter instance
// shares the stimulus to exercise counter saturation.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic        bt_hit, bt_pred;
    logic [31:0] bt_dest;
    logic        resolve_valid, resolve_taken;
    logic [31:0] resolve_target;
    logic        jump_valid;
    logic [31:0] jump_target;

    logic [31:0] imem_addr, pc4, id_pc4, bt_destin, bt_pc4d;
    logic        id_valid, id_pred_taken, flush, bt_wrt, bt_wrp, bt_pin;
    logic [15:0] branch_cnt, mispred_cnt;

    logic [31:0] s_imem_addr, s_pc4, s_id_pc4, s_bt_destin, s_bt_pc4d;
    logic        s_id_valid, s_id_pred_taken, s_flush;
    logic        s_bt_wrt, s_bt_wrp, s_bt_pin;
    logic [2:0]  s_branch_cnt, s_mispred_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall),
        .imem_addr(imem_addr), .pc4(pc4),
        .bt_hit(bt_hit), .bt_pred(bt_pred), .bt_dest(bt_dest),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .jump_valid(jump_valid), .jump_target(jump_target),
        .id_valid(id_valid), .id_pc4(id_pc4),
        .id_pred_taken(id_pred_taken), .flush(flush),
        .bt_wrt(bt_wrt), .bt_wrp(bt_wrp), .bt_pin(bt_pin),
        .bt_destin(bt_destin), .bt_pc4d(bt_pc4d),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    fetch_pc_ctrl #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall),
        .imem_addr(s_imem_addr), .pc4(s_pc4),
        .bt_hit(bt_hit), .bt_pred(bt_pred), .bt_dest(bt_dest),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .jump_valid(jump_valid), .jump_target(jump_target),
        .id_valid(s_id_valid), .id_pc4(s_id_pc4),
        .id_pred_taken(s_id_pred_taken), .flush(s_flush),
        .bt_wrt(s_bt_wrt), .bt_wrp(s_bt_wrp), .bt_pin(s_bt_pin),
        .bt_destin(s_bt_destin), .bt_pc4d(s_bt_pc4d),
        .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0;
        bt_hit = 1'b0; bt_pred = 1'b0; bt_dest = 32'h0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = 32'h0;
        jump_valid = 1'b0; jump_target = 32'h0;
        step(); step();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", imem_addr, 32'h0); end
        checks++; if (pc4 !== 32'h4) begin errors++; $display("FAIL rst_pc4 got %h exp %h", pc4, 32'h4); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_idv got %b exp 0", id_valid); end
        checks++; if ({bt_wrt, bt_wrp, bt_pin} !== 3'b000) begin errors++; $display("FAIL rst_strb got %b exp 000", {bt_wrt, bt_wrp, bt_pin}); end
        checks++; if (branch_cnt !== 16'h0 || mispred_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt got %h/%h exp 0/0", branch_cnt, mispred_cnt); end
        rst = 1'b0;
        step();
        checks++; if (imem_addr !== 32'h4 || id_valid !== 1'b1 || id_pc4 !== 32'h4) begin errors++; $display("FAIL seq1 got pc %h v %b ipc4 %h exp 4 1 4", imem_addr, id_valid, id_pc4); end
        step();
        checks++; if (imem_addr !== 32'h8 || id_pc4 !== 32'h8) begin errors++; $display("FAIL seq2 got pc %h ipc4 %h exp 8 8", imem_addr, id_pc4); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL seq_flush got %b exp 0", flush); end
    endtask

    task automatic test_taken_miss();
        step();
        resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_target = 32'h40;
        settle();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL tm_flush got %b exp 1", flush); end
        step();
        resolve_valid = 1'b0;
        checks++; if (imem_addr !== 32'h40 || id_valid !== 1'b0) begin errors++; $display("FAIL tm_redir got pc %h v %b exp 40 0", imem_addr, id_valid); end
        checks++; if ({bt_wrt, bt_wrp, bt_pin} !== 3'b111) begin errors++; $display("FAIL tm_strb got %b exp 111", {bt_wrt, bt_wrp, bt_pin}); end
        checks++; if (bt_pc4d !== 32'hC || bt_destin !== 32'h40) begin errors++; $display("FAIL tm_data got %h/%h exp c/40", bt_pc4d, bt_destin); end
        checks++; if (mispred_cnt !== 16'd1 || branch_cnt !== 16'd1) begin errors++; $display("FAIL tm_cnt got %0d/%0d exp 1/1", branch_cnt, mispred_cnt); end
        step();
        checks++; if ({bt_wrt, bt_wrp, bt_pin} !== 3'b000) begin errors++; $display("FAIL tm_pulse got %b exp 000", {bt_wrt, bt_wrp, bt_pin}); end
        checks++; if (imem_addr !== 32'h44 || id_valid !== 1'b1) begin errors++; $display("FAIL tm_bubble got pc %h v %b exp 44 1", imem_addr, id_valid); end
    endtask

    task automatic test_hit_taken();
        jump_valid = 1'b1; jump_target = 32'h8;
        settle();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jmp_flush got %b exp 1", flush); end
        step();
        jump_valid = 1'b0;
        checks++; if (imem_addr !== 32'h8 || id_valid !== 1'b0) begin errors++; $display("FAIL jmp_pc got pc %h v %b exp 8 0", imem_addr, id_valid); end
        bt_hit = 1'b1; bt_pred = 1'b1; bt_dest = 32'h40;
        step();
        bt_hit = 1'b0; bt_pred = 1'b0; bt_dest = 32'h0;
        checks++; if (imem_addr !== 32'h40 || id_valid !== 1'b1 || id_pred_taken !== 1'b1) begin errors++; $display("FAIL ht_fetch got pc %h v %b p %b exp 40 1 1", imem_addr, id_valid, id_pred_taken); end
        resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_target = 32'h40;
        settle();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL ht_flush got %b exp 0", flush); end
        step();
        resolve_valid = 1'b0;
        checks++; if ({bt_wrt, bt_wrp, bt_pin} !== 3'b011) begin errors++; $display("FAIL ht_strb got %b exp 011", {bt_wrt, bt_wrp, bt_pin}); end
        checks++; if (imem_addr !== 32'h44 || id_valid !== 1'b1) begin errors++; $display("FAIL ht_next got pc %h v %b exp 44 1", imem_addr, id_valid); end
        checks++; if (branch_cnt !== 16'd2 || mispred_cnt !== 16'd1) begin errors++; $display("FAIL ht_cnt got %0d/%0d exp 2/1", branch_cnt, mispred_cnt); end
    endtask

    task automatic test_hit_not_taken();
        jump_valid = 1'b1; jump_target = 32'h8;
        step();
        jump_valid = 1'b0;
        bt_hit = 1'b1; bt_pred = 1'b1; bt_dest = 32'h40;
        step();
        bt_hit = 1'b0; bt_pred = 1'b0; bt_dest = 32'h0;
        resolve_valid = 1'b1; resolve_taken = 1'b0; resolve_target = 32'h40;
        settle();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL hn_flush got %b exp 1", flush); end
        step();
        resolve_valid = 1'b0;
        checks++; if (imem_addr !== 32'hC || id_valid !== 1'b0) begin errors++; $display("FAIL hn_pc got pc %h v %b exp c 0", imem_addr, id_valid); end
        checks++; if ({bt_wrt, bt_wrp, bt_pin} !== 3'b010) begin errors++; $display("FAIL hn_strb got %b exp 010", {bt_wrt, bt_wrp, bt_pin}); end
        checks++; if (branch_cnt !== 16'd3 || mispred_cnt !== 16'd2) begin errors++; $display("FAIL hn_cnt got %0d/%0d exp 3/2", branch_cnt, mispred_cnt); end
    endtask

    task automatic test_stall();
        step();
        checks++; if (imem_addr !== 32'h10 || id_pc4 !== 32'h10) begin errors++; $display("FAIL st_pre got pc %h ipc4 %h exp 10 10", imem_addr, id_pc4); end
        stall = 1'b1;
        resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_target = 32'h80;
        settle();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL st_flush got %b exp 0", flush); end
        step(); step();
        checks++; if (imem_addr !== 32'h10 || id_pc4 !== 32'h10 || id_valid !== 1'b1) begin errors++; $display("FAIL st_hold got pc %h ipc4 %h v %b exp 10 10 1", imem_addr, id_pc4, id_valid); end
        checks++; if ({bt_wrt, bt_wrp, bt_pin} !== 3'b000) begin errors++; $display("FAIL st_strb got %b exp 000", {bt_wrt, bt_wrp, bt_pin}); end
        checks++; if (branch_cnt !== 16'd3 || mispred_cnt !== 16'd2) begin errors++; $display("FAIL st_cnt got %0d/%0d exp 3/2", branch_cnt, mispred_cnt); end
        stall = 1'b0;
        settle();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL st_rel_flush got %b exp 1", flush); end
        step();
        resolve_valid = 1'b0;
        checks++; if (imem_addr !== 32'h80 || id_valid !== 1'b0) begin errors++; $display("FAIL st_rel_pc got pc %h v %b exp 80 0", imem_addr, id_valid); end
        checks++; if ({bt_wrt, bt_wrp, bt_pin} !== 3'b111 || bt_pc4d !== 32'h10 || bt_destin !== 32'h80) begin errors++; $display("FAIL st_rel_strb got %b %h %h exp 111 10 80", {bt_wrt, bt_wrp, bt_pin}, bt_pc4d, bt_destin); end
        checks++; if (branch_cnt !== 16'd4 || mispred_cnt !== 16'd3) begin errors++; $display("FAIL st_rel_cnt got %0d/%0d exp 4/3", branch_cnt, mispred_cnt); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            resolve_valid = 1'b0;
            step();
            resolve_valid = 1'b1; resolve_taken = 1'b1;
            resolve_target = 32'h100 + 32'(i) * 32'h10;
            step();
        end
        resolve_valid = 1'b0;
        checks++; if (imem_addr !== 32'h150) begin errors++; $display("FAIL bb_pc got %h exp 150", imem_addr); end
        checks++; if (branch_cnt !== 16'd10 || mispred_cnt !== 16'd9) begin errors++; $display("FAIL bb_cnt got %0d/%0d exp 10/9", branch_cnt, mispred_cnt); end
        checks++; if (s_branch_cnt !== 3'd7 || s_mispred_cnt !== 3'd7) begin errors++; $display("FAIL sat_cnt got %0d/%0d exp 7/7", s_branch_cnt, s_mispred_cnt); end
    endtask

    task automatic test_reset_mid_redirect();
        step();
        resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_target = 32'h200;
        rst = 1'b1;
        settle();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rr_flush got %b exp 1", flush); end
        step();
        rst = 1'b0; resolve_valid = 1'b0;
        checks++; if (imem_addr !== 32'h0 || id_valid !== 1'b0) begin errors++; $display("FAIL rr_pc got pc %h v %b exp 0 0", imem_addr, id_valid); end
        checks++; if ({bt_wrt, bt_wrp, bt_pin} !== 3'b000 || bt_pc4d !== 32'h0) begin errors++; $display("FAIL rr_strb got %b %h exp 000 0", {bt_wrt, bt_wrp, bt_pin}, bt_pc4d); end
        checks++; if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0 || s_mispred_cnt !== 3'd0) begin errors++; $display("FAIL rr_cnt got %0d/%0d/%0d exp 0/0/0", branch_cnt, mispred_cnt, s_mispred_cnt); end
        step();
        checks++; if ({bt_wrt, bt_wrp, bt_pin} !== 3'b000 || imem_addr !== 32'h4) begin errors++; $display("FAIL rr_after got %b pc %h exp 000 4", {bt_wrt, bt_wrp, bt_pin}, imem_addr); end
    endtask

    task automatic test_pc_wrap();
        jump_valid = 1'b1; jump_target = 32'hFFFF_FFFC;
        step();
        jump_valid = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC || pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got pc %h pc4 %h exp fffffffc 0", imem_addr, pc4); end
        step();
        checks++; if (imem_addr !== 32'h0 || id_pc4 !== 32'h0 || id_valid !== 1'b1) begin errors++; $display("FAIL wrap_next got pc %h ipc4 %h v %b exp 0 0 1", imem_addr, id_pc4, id_valid); end
    endtask

    initial begin
        test_reset();
        test_taken_miss();
        test_hit_taken();
        test_hit_not_taken();
        test_stall();
        test_back_to_back();
        test_reset_mid_redirect();
        test_pc_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
